// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a local tick divider and registered byte/strobe outputs.
// rx_valid / frame_err appear 3 + 152*OSR_DIV cycles after rxd is first sampled low.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned OSR_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    // OSR_DIV must be at least 2.
    localparam int unsigned DIV_W = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(OSR_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             rxd_s;
    logic             fall_c;

    assign rxd_s  = sync2_q;
    assign fall_c = sync3_q & ~rxd_s;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            tick_q      <= 1'b0;
            scnt_q      <= 4'd0;
            bcnt_q      <= 3'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; the divider is held at 0 in IDLE so it restarts aligned to the start edge.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tick_d      = 1'b0;
        scnt_d      = scnt_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = (state_q != IDLE);

        if (state_q == IDLE || div_q == DIV_MAX) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        tick_d = (state_q != IDLE) && (div_q == DIV_MAX);

        unique case (state_q)
            IDLE: begin
                if (fall_c) begin
                    scnt_d  = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (tick_q) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd7) begin
                        if (rxd_s) begin
                            state_d = IDLE;
                        end else begin
                            scnt_d  = 4'd0;
                            bcnt_d  = 3'd0;
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (tick_q) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shreg_d = {rxd_s, shreg_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick_q) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        if (rxd_s) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames, back-to-back, glitch, framing error, reset abort, baud skew.
module tb_uart_rx;

    localparam int unsigned OSR = 27;
    localparam int unsigned LAT = 3 + 152 * OSR;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_k = 0;
    int         vcnt = 0;
    int         fcnt = 0;
    int         fcyc = 0;
    int         busy_rise = 0;
    int         busy_fall = 0;
    logic       busy_prev = 1'b0;
    logic       both_seen = 1'b0;
    logic [7:0] vdata[$];
    int         vcyc[$];

    uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and busy-edge recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt <= vcnt + 1;
            vdata.push_back(rx_data);
            vcyc.push_back(cyc);
        end
        if (frame_err) begin
            fcnt <= fcnt + 1;
            fcyc <= cyc;
        end
        if (rx_valid && frame_err) both_seen <= 1'b1;
        if (busy && !busy_prev) busy_rise <= cyc;
        if (!busy && busy_prev) busy_fall <= cyc;
        busy_prev <= busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame starting right after a falling clock edge; leaves the line high.
    task automatic send_frame(input logic [7:0] d, input int bit_clks, input logic stop);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            if (i == 0) last_k = cyc + 1;
            repeat (bit_clks) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0;
        int f0;
        int gk;
        logic [7:0] b55;

        // Reset state
        idle(3);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(1000);

        // Good frame 0xA5
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'hA5, 432, 1'b1);
        idle(500);
        check("good_count", 32'(vcnt), 32'(v0 + 1));
        check("good_data", 32'(vdata[$]), 32'hA5);
        check("good_latency", 32'(vcyc[$]), 32'(last_k + LAT));
        check("good_busy_rise", 32'(busy_rise), 32'(last_k + 3));
        check("good_no_ferr", 32'(fcnt), 32'(f0));
        check("good_busy_low", 32'(busy), 32'h0);

        // Back-to-back 0x00, 0xFF, 0x3C
        idle(1000);
        v0 = vcnt;
        send_frame(8'h00, 432, 1'b1);
        send_frame(8'hFF, 432, 1'b1);
        send_frame(8'h3C, 432, 1'b1);
        idle(500);
        check("b2b_count", 32'(vcnt), 32'(v0 + 3));
        check("b2b_byte0", 32'(vdata[v0]), 32'h00);
        check("b2b_byte1", 32'(vdata[v0 + 1]), 32'hFF);
        check("b2b_byte2", 32'(vdata[v0 + 2]), 32'h3C);
        check("b2b_gap01", 32'(vcyc[v0 + 1] - vcyc[v0]), 32'd4320);
        check("b2b_gap12", 32'(vcyc[v0 + 2] - vcyc[v0 + 1]), 32'd4320);
        check("b2b_no_ferr", 32'(fcnt), 32'(f0));

        // Glitch reject: 5-clock low pulse
        idle(1000);
        v0 = vcnt;
        rxd = 1'b0;
        gk = cyc + 1;
        idle(5);
        rxd = 1'b1;
        idle(400);
        check("glitch_busy_rise", 32'(busy_rise), 32'(gk + 3));
        check("glitch_busy_fall", 32'(busy_fall), 32'(gk + 220));
        check("glitch_no_valid", 32'(vcnt), 32'(v0));
        check("glitch_no_ferr", 32'(fcnt), 32'(f0));

        // Framing error: 0x81 with low stop bit
        idle(1000);
        send_frame(8'h81, 432, 1'b0);
        idle(500);
        check("ferr_count", 32'(fcnt), 32'(f0 + 1));
        check("ferr_latency", 32'(fcyc), 32'(last_k + LAT));
        check("ferr_data_held", 32'(rx_data), 32'h3C);
        check("ferr_no_valid", 32'(vcnt), 32'(v0));
        f0 = f0 + 1;

        // Reset during data bit 4 of 0x55
        idle(1000);
        b55 = 8'h55;
        rxd = 1'b0;
        idle(432);
        for (int i = 0; i < 4; i++) begin
            rxd = b55[i];
            idle(432);
        end
        rxd = b55[4];
        idle(200);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rx_data", 32'(rx_data), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
        idle(3);
        rst_n = 1'b1;
        rxd = 1'b1;
        idle(5000);
        check("rst_abort_no_valid", 32'(vcnt), 32'(v0));
        check("rst_abort_no_ferr", 32'(fcnt), 32'(f0));
        send_frame(8'h96, 432, 1'b1);
        idle(500);
        check("rst_after_count", 32'(vcnt), 32'(v0 + 1));
        check("rst_after_data", 32'(rx_data), 32'h96);

        // Baud tolerance at -3% and +3%
        idle(1000);
        v0 = vcnt;
        send_frame(8'hC3, 419, 1'b1);
        idle(500);
        check("baud_fast_data", 32'(rx_data), 32'hC3);
        check("baud_fast_count", 32'(vcnt), 32'(v0 + 1));
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1000);
        check("baud_cleared", 32'(rx_data), 32'h00);
        send_frame(8'hC3, 445, 1'b1);
        idle(500);
        check("baud_slow_data", 32'(rx_data), 32'hC3);
        check("baud_slow_count", 32'(vcnt), 32'(v0 + 2));
        check("baud_no_ferr", 32'(fcnt), 32'(f0));

        check("no_overlap", 32'(both_seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
